kmeans_centroid_accum: RTL and testbench



---
 rtl/kmeans_centroid_accum.sv | 208 ++++++++++++++++++++
 tb/tb_kmeans_centroid_accum.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_centroid_accum.sv
// -----------------------------------------------------------------------------
// kmeans_centroid_accum
// Streaming per-cluster accumulator that sits behind the k-means product
// multiplier. Each accepted beat adds its signed product into the running sum
// of its cluster and bumps that cluster's point count. When the beat marked
// s_last has been absorbed, one record per cluster is drained (cluster 0 first)
// and each cluster's state is cleared as its record is taken.
//
// Ports
//   ap_clk, ap_rst_n : clock, synchronous active-low reset
//   s_valid/s_ready  : input beat handshake (ready only while accumulating)
//   s_cluster        : cluster index of the beat (>= K is dropped, sets err)
//   s_prod           : signed product, sign-extended into the accumulator
//   s_last           : final beat of the pass, starts the drain
//   m_valid/m_ready  : drain record handshake
//   m_cluster        : cluster index of the record
//   m_sum, m_count   : accumulated sum / point count for that cluster
//   m_last           : record for cluster K-1
//   err              : sticky, out-of-range index or count saturation seen
// -----------------------------------------------------------------------------
module kmeans_centroid_accum #(
   parameter int unsigned K      = 4,
   parameter int unsigned CL_W   = 2,
   parameter int unsigned PROD_W = 11,
   parameter int unsigned SUM_W  = 32,
   parameter int unsigned CNT_W  = 20
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [CL_W-1:0]   s_cluster,
   input  logic [PROD_W-1:0] s_prod,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CL_W-1:0]   m_cluster,
   output logic [SUM_W-1:0]  m_sum,
   output logic [CNT_W-1:0]  m_count,
   output logic              m_last,
   output logic              err
);

   localparam int unsigned EXT_W = SUM_W - PROD_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CL_W-1:0]  d_q;
   logic [CL_W-1:0]  d_nxt;

   logic [SUM_W-1:0] sum_q   [K];
   logic [SUM_W-1:0] sum_nxt [K];
   logic [CNT_W-1:0] cnt_q   [K];
   logic [CNT_W-1:0] cnt_nxt [K];
   logic             err_nxt;

   logic             accept;
   logic             drain_hs;
   logic             last_rec;
   logic [SUM_W-1:0] prod_ext;
   logic [SUM_W-1:0] rd_sum;
   logic [CNT_W-1:0] rd_cnt;

   // Handshake qualifiers; s_ready mirrors the ACCUM state exactly.
   assign accept   = s_valid && (state == ST_ACCUM);
   assign drain_hs = (state == ST_DRAIN) && m_ready;
   assign last_rec = (d_q == CL_W'(K - 1));
   assign prod_ext = {{EXT_W{s_prod[PROD_W-1]}}, s_prod};

   // State register.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state <= ST_IDLE;
         d_q   <= '0;
      end else begin
         state <= state_nxt;
         d_q   <= d_nxt;
      end
   end

   // Next-state and drain-index logic.
   always_comb begin
      state_nxt = state;
      d_nxt     = d_q;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_ACCUM;
            d_nxt     = '0;
         end
         ST_ACCUM: begin
            if (accept && s_last) begin
               state_nxt = ST_DRAIN;
               d_nxt     = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_hs) begin
               if (last_rec) begin
                  state_nxt = ST_ACCUM;
                  d_nxt     = '0;
               end else begin
                  d_nxt = d_q + CL_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            d_nxt     = '0;
         end
      endcase
   end

   // Per-cluster accumulate / clear-on-drain; the reset is folded in here so
   // the array registers below are a plain whole-array update.
   always_comb begin
      sum_nxt = sum_q;
      cnt_nxt = cnt_q;
      err_nxt = err;

      if (accept) begin
         if (32'(s_cluster) >= K) begin
            err_nxt = 1'b1;
         end else begin
            for (int k = 0; k < int'(K); k++) begin
               if (s_cluster == CL_W'(k)) begin
                  // A saturated count freezes both sum and count so the
                  // record stays self-consistent.
                  if (&cnt_q[k]) begin
                     err_nxt = 1'b1;
                  end else begin
                     sum_nxt[k] = sum_q[k] + prod_ext;
                     cnt_nxt[k] = cnt_q[k] + CNT_W'(1);
                  end
               end
            end
         end
      end

      if (drain_hs) begin
         for (int k = 0; k < int'(K); k++) begin
            if (d_q == CL_W'(k)) begin
               sum_nxt[k] = '0;
               cnt_nxt[k] = '0;
            end
         end
      end

      if (!ap_rst_n) begin
         for (int k = 0; k < int'(K); k++) begin
            sum_nxt[k] = '0;
            cnt_nxt[k] = '0;
         end
         err_nxt = 1'b0;
      end
   end

   // Accumulator arrays.
   always_ff @(posedge ap_clk) begin
      sum_q <= sum_nxt;
      cnt_q <= cnt_nxt;
   end

   // Record read port: looks at the post-update arrays so the first record
   // already includes the s_last beat.
   always_comb begin
      rd_sum = '0;
      rd_cnt = '0;
      for (int k = 0; k < int'(K); k++) begin
         if (d_nxt == CL_W'(k)) begin
            rd_sum = sum_nxt[k];
            rd_cnt = cnt_nxt[k];
         end
      end
   end

   // Registered outputs, loaded from the next-state view.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         m_cluster <= '0;
         m_sum     <= '0;
         m_count   <= '0;
         m_last    <= 1'b0;
         err       <= 1'b0;
      end else begin
         s_ready <= (state_nxt == ST_ACCUM);
         m_valid <= (state_nxt == ST_DRAIN);
         err     <= err_nxt;
         if (state_nxt == ST_DRAIN) begin
            m_cluster <= d_nxt;
            m_sum     <= rd_sum;
            m_count   <= rd_cnt;
            m_last    <= (d_nxt == CL_W'(K - 1));
         end else begin
            m_cluster <= '0;
            m_sum     <= '0;
            m_count   <= '0;
            m_last    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kmeans_centroid_accum.sv
// -----------------------------------------------------------------------------
// Bench for kmeans_centroid_accum. Instance A uses the default parameters;
// instance B uses K=3, CNT_W=3 for the out-of-range and saturation cases.
// Inputs are shared, each instance has its own reset and the idle one is held
// in reset; "sel" picks which instance is observed.
// -----------------------------------------------------------------------------
module tb_kmeans_centroid_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic        s_valid, s_last, m_ready;
   logic [1:0]  s_cluster;
   logic [10:0] s_prod;

   logic        a_s_ready, a_m_valid, a_m_last, a_err;
   logic [1:0]  a_m_cluster;
   logic [31:0] a_m_sum;
   logic [19:0] a_m_count;

   logic        b_s_ready, b_m_valid, b_m_last, b_err;
   logic [1:0]  b_m_cluster;
   logic [31:0] b_m_sum;
   logic [2:0]  b_m_count;

   kmeans_centroid_accum u_dut_a (
      .ap_clk(clk), .ap_rst_n(rst_a),
      .s_valid(s_valid), .s_ready(a_s_ready), .s_cluster(s_cluster),
      .s_prod(s_prod), .s_last(s_last),
      .m_valid(a_m_valid), .m_ready(m_ready), .m_cluster(a_m_cluster),
      .m_sum(a_m_sum), .m_count(a_m_count), .m_last(a_m_last), .err(a_err)
   );

   kmeans_centroid_accum #(.K(3), .CL_W(2), .PROD_W(11), .SUM_W(32), .CNT_W(3)) u_dut_b (
      .ap_clk(clk), .ap_rst_n(rst_b),
      .s_valid(s_valid), .s_ready(b_s_ready), .s_cluster(s_cluster),
      .s_prod(s_prod), .s_last(s_last),
      .m_valid(b_m_valid), .m_ready(m_ready), .m_cluster(b_m_cluster),
      .m_sum(b_m_sum), .m_count(b_m_count), .m_last(b_m_last), .err(b_err)
   );

   bit          sel;
   logic        ob_ready, ob_mvalid, ob_mlast, ob_err;
   logic [1:0]  ob_mcl;
   logic [31:0] ob_msum;
   logic [19:0] ob_mcount;

   assign ob_ready  = sel ? b_s_ready   : a_s_ready;
   assign ob_mvalid = sel ? b_m_valid   : a_m_valid;
   assign ob_mlast  = sel ? b_m_last    : a_m_last;
   assign ob_err    = sel ? b_err       : a_err;
   assign ob_mcl    = sel ? b_m_cluster : a_m_cluster;
   assign ob_msum   = sel ? b_m_sum     : a_m_sum;
   assign ob_mcount = sel ? 20'(b_m_count) : a_m_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain per-cluster totals following the block's rules.
   int msum [4];
   int mcnt [4];
   bit merr;
   int kc;
   int cmax;

   int got_sum  [4];
   int got_cnt  [4];
   bit got_last [4];

   typedef struct {int cl; int prod; bit last;} beat_t;
   typedef struct {int sum; int cnt; bit last;} rec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         msum[i] = 0;
         mcnt[i] = 0;
      end
      merr = 1'b0;
   endtask

   task automatic model_accept(input int cl, input int prod);
      if (cl >= kc) merr = 1'b1;
      else if (mcnt[cl] == cmax) merr = 1'b1;
      else begin
         msum[cl] += prod;
         mcnt[cl] += 1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, ob_ready, 0);
      chk({tag, "_m_valid"}, ob_mvalid, 0);
      chk({tag, "_m_cluster"}, ob_mcl, 0);
      chk({tag, "_m_sum"}, ob_msum, 0);
      chk({tag, "_m_count"}, ob_mcount, 0);
      chk({tag, "_m_last"}, ob_mlast, 0);
      chk({tag, "_err"}, ob_err, 0);
   endtask

   // Reset both instances, then bring the selected one up.
   task automatic do_reset(input bit b);
      s_valid = 0; s_last = 0; s_cluster = 0; s_prod = 0; m_ready = 1;
      rst_a = 0; rst_b = 0;
      sel = b;
      kc = b ? 3 : 4;
      cmax = b ? 7 : (1 << 20) - 1;
      repeat (3) tick();
      model_reset();
      check_reset_outputs("reset");
      if (b) rst_b = 1; else rst_a = 1;
      chk("startup_idle_ready", ob_ready, 0);
      tick();
      chk("startup_ready", ob_ready, 1);
   endtask

   task automatic send_beat(input int cl, input int prod, input bit last);
      int n;
      s_valid = 1; s_cluster = 2'(cl); s_prod = 11'(prod); s_last = last;
      n = 0;
      while (!ob_ready && n < 20) begin
         tick();
         n++;
      end
      if (!ob_ready) chk("beat_ready_timeout", ob_ready, 1);
      else begin
         tick();
         model_accept(cl, prod);
      end
      s_valid = 0; s_last = 0;
   endtask

   // Drain every record, comparing against the model; optional stall at one
   // index (with an input beat offered that must be ignored) or random stalls.
   task automatic drain(input int stall_d, input int stall_n, input bit rnd);
      int nst;
      for (int d = 0; d < kc; d++) begin
         chk("rec_valid", ob_mvalid, 1);
         chk("rec_cluster", ob_mcl, d);
         chk("rec_sum", $signed(ob_msum), msum[d]);
         chk("rec_count", ob_mcount, mcnt[d]);
         chk("rec_last", ob_mlast, (d == kc - 1));
         chk("rec_s_ready_low", ob_ready, 0);
         got_sum[d]  = $signed(ob_msum);
         got_cnt[d]  = int'(ob_mcount);
         got_last[d] = ob_mlast;
         if (d == stall_d) nst = stall_n;
         else if (rnd && $urandom_range(0, 3) == 0) nst = $urandom_range(1, 3);
         else nst = 0;
         if (nst > 0) begin
            m_ready = 0;
            s_valid = 1; s_cluster = 0; s_prod = 11'(7); s_last = 1;
            repeat (nst) begin
               tick();
               chk("stall_valid", ob_mvalid, 1);
               chk("stall_cluster", ob_mcl, d);
               chk("stall_sum", $signed(ob_msum), msum[d]);
               chk("stall_count", ob_mcount, mcnt[d]);
               chk("stall_s_ready", ob_ready, 0);
            end
            s_valid = 0; s_last = 0;
            m_ready = 1;
         end
         tick();
         msum[d] = 0;
         mcnt[d] = 0;
      end
      chk("drain_done_ready", ob_ready, 1);
      chk("drain_done_valid", ob_mvalid, 0);
   endtask

   task automatic rand_pass(input int nbeats, input bit oor_ok);
      int cl, prod;
      for (int i = 0; i < nbeats; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         cl = oor_ok ? int'($urandom_range(0, 3)) : int'($urandom_range(0, kc - 1));
         prod = int'($urandom_range(0, 2047)) - 1024;
         send_beat(cl, prod, i == nbeats - 1);
      end
      chk("pass_err", ob_err, merr);
      drain(-1, 0, 1'b1);
   endtask

   beat_t basic [3];
   rec_t  basic_exp [4];
   beat_t ext [7];

   initial begin
      basic[0] = '{1, 5, 1'b0};
      basic[1] = '{1, -7, 1'b0};
      basic[2] = '{3, 100, 1'b1};
      basic_exp[0] = '{0, 0, 1'b0};
      basic_exp[1] = '{-2, 2, 1'b0};
      basic_exp[2] = '{0, 0, 1'b0};
      basic_exp[3] = '{100, 1, 1'b1};
      for (int i = 0; i < 3; i++) ext[i] = '{3, 1023, 1'b0};
      for (int i = 3; i < 7; i++) ext[i] = '{0, -1024, (i == 6)};

      // ---------------- instance A ----------------
      do_reset(1'b0);

      // Basic pass, checked against the hand-written record table.
      for (int i = 0; i < 3; i++) send_beat(basic[i].cl, basic[i].prod, basic[i].last);
      chk("basic_err", ob_err, 0);
      drain(-1, 0, 1'b0);
      for (int d = 0; d < 4; d++) begin
         chk("basic_tbl_sum", got_sum[d], basic_exp[d].sum);
         chk("basic_tbl_cnt", got_cnt[d], basic_exp[d].cnt);
         chk("basic_tbl_last", got_last[d], basic_exp[d].last);
      end

      // Extremes, back-to-back beats to the same cluster.
      for (int i = 0; i < 7; i++) send_beat(ext[i].cl, ext[i].prod, ext[i].last);
      drain(-1, 0, 1'b0);
      chk("ext_sum0", got_sum[0], -4096);
      chk("ext_cnt0", got_cnt[0], 4);
      chk("ext_sum3", got_sum[3], 3069);
      chk("ext_cnt3", got_cnt[3], 3);

      // Backpressure on cluster 2; the beat offered during the stall must vanish.
      send_beat(2, 11, 0);
      send_beat(2, -300, 0);
      send_beat(1, 40, 1);
      drain(2, 5, 1'b0);
      chk("bp_sum2", got_sum[2], -289);
      chk("bp_cnt2", got_cnt[2], 2);
      send_beat(1, 3, 1);
      drain(-1, 0, 1'b0);
      chk("bp_no_leak_sum0", got_sum[0], 0);
      chk("bp_no_leak_cnt0", got_cnt[0], 0);

      for (int p = 0; p < 8; p++) rand_pass(int'($urandom_range(1, 40)), 1'b0);

      // ---------------- instance B (K=3, CNT_W=3) ----------------
      do_reset(1'b1);
      send_beat(3, 50, 1);
      chk("oor_err", ob_err, 1);
      drain(-1, 0, 1'b0);
      for (int d = 0; d < 3; d++) chk("oor_rec_zero", got_cnt[d] + got_sum[d], 0);
      chk("oor_last", got_last[2], 1);

      do_reset(1'b1);
      for (int i = 0; i < 9; i++) send_beat(2, 1, 0);
      send_beat(0, 0, 1);
      chk("sat_err", ob_err, 1);
      drain(-1, 0, 1'b0);
      chk("sat_cnt2", got_cnt[2], 7);
      chk("sat_sum2", got_sum[2], 7);

      for (int p = 0; p < 8; p++) rand_pass(int'($urandom_range(1, 30)), 1'b1);

      // Reset in the middle of a drain.
      do_reset(1'b1);
      send_beat(3, 9, 0);
      send_beat(1, 20, 0);
      send_beat(2, -5, 1);
      for (int d = 0; d < 2; d++) begin
         chk("mid_rec_sum", $signed(ob_msum), msum[d]);
         chk("mid_rec_cluster", ob_mcl, d);
         tick();
      end
      chk("mid_err_before", ob_err, 1);
      rst_b = 0;
      tick();
      chk("mid_rst_m_valid", ob_mvalid, 0);
      chk("mid_rst_err", ob_err, 0);
      chk("mid_rst_s_ready", ob_ready, 0);
      chk("mid_rst_m_sum", ob_msum, 0);
      rst_b = 1;
      model_reset();
      chk("mid_restart_idle", ob_ready, 0);
      tick();
      chk("mid_restart_ready", ob_ready, 1);
      send_beat(2, 4, 1);
      chk("mid_err_after", ob_err, 0);
      drain(-1, 0, 1'b0);
      chk("mid_sum1_cleared", got_sum[1], 0);
      chk("mid_sum2_fresh", got_sum[2], 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
